// File: rtl/route_sequencer.sv
// Route sequencer: walks a train route through 16 steps. Each step waits for a
// debounced condition from the downstream selector and flags an overlong dwell.
module route_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned DWELL_CYCLES    = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic       Abort,
    input  logic       Y,
    output logic [4:0] Selector,
    output logic       Enable,
    output logic       TIMER,
    output logic [1:0] Motor,
    output logic       Busy,
    output logic       Done
);

    typedef enum logic [2:0] {
        sIdle,
        sArm,
        sWait,
        sAdvance,
        sDone
    } stateT;

    localparam logic [1:0]  MotorStop    = 2'b00;
    localparam logic [1:0]  MotorFwd     = 2'b01;
    localparam logic [1:0]  MotorRev     = 2'b10;
    localparam logic [7:0]  DebounceLast = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] DwellLimit   = 16'(DWELL_CYCLES);

    stateT       state;
    stateT       nextState;
    logic [3:0]  step;
    logic [7:0]  debounceCnt;
    logic [15:0] dwellCnt;
    logic        conditionMet;
    logic        lastStep;
    logic        abortRun;

    // The step index is only four bits wide, so Selector can never exceed 15.
    assign conditionMet = Y && (debounceCnt == DebounceLast);
    assign lastStep     = (step == 4'd15);
    assign abortRun     = Abort && (state != sIdle);

    function automatic logic [1:0] motorFor(input logic [3:0] s);
        if (s <= 4'd5)      return MotorFwd;
        else if (s <= 4'd9) return MotorStop;
        else                return MotorRev;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= sIdle;
        else     state <= nextState;
    end

    // NOTE: nextState is given a default before the case so no path through
    // this combinational block leaves it unassigned (which would infer a latch).
    always_comb begin
        nextState = state;
        unique case (state)
            sIdle:    if (Start && !Abort) nextState = sArm;
            sArm:     nextState = sWait;
            sWait:    if (conditionMet) nextState = sAdvance;
            sAdvance: nextState = lastStep ? sDone : sArm;
            sDone:    nextState = sIdle;
            default:  nextState = sIdle;
        endcase
        if (abortRun) nextState = sIdle;
    end

    // NOTE: these counters are control state, so they take the asynchronous
    // reset along with the state register; nothing here is a memory array.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            step        <= '0;
            debounceCnt <= '0;
            dwellCnt    <= '0;
        end else if (abortRun) begin
            step        <= '0;
            debounceCnt <= '0;
            dwellCnt    <= '0;
        end else begin
            unique case (state)
                sIdle: begin
                    step        <= '0;
                    debounceCnt <= '0;
                    dwellCnt    <= '0;
                end
                sArm: begin
                    debounceCnt <= '0;
                    dwellCnt    <= '0;
                end
                sWait: begin
                    debounceCnt <= Y ? debounceCnt + 8'd1 : '0;
                    if (dwellCnt != DwellLimit) dwellCnt <= dwellCnt + 16'd1;
                end
                sAdvance: if (!lastStep) step <= step + 4'd1;
                sDone:    step <= '0;
                default:  step <= '0;
            endcase
        end
    end

    // Outputs decode only registered state, so none of them depends on an input.
    always_comb begin
        Selector = {1'b0, step};
        Enable   = 1'b0;
        TIMER    = 1'b0;
        Motor    = MotorStop;
        Busy     = 1'b1;
        Done     = 1'b0;
        unique case (state)
            sIdle: Busy = 1'b0;
            sArm: begin
                Enable = 1'b1;
                Motor  = motorFor(step);
            end
            sWait: begin
                Enable = 1'b1;
                TIMER  = (dwellCnt == DwellLimit);
                Motor  = motorFor(step);
            end
            sAdvance: Motor = motorFor(step);
            sDone:    Done  = 1'b1;
            default:  Busy  = 1'b0;
        endcase
    end

    assert property (@(posedge CLK) disable iff (RST) Motor != 2'b11);
    assert property (@(posedge CLK) disable iff (RST) Done |=> !Done);

endmodule

// File: doc/route_sequencer.md
ROUTE_SEQUENCER -- requirements
Module: route_sequencer

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 4, consecutive WAIT cycles with Y=1 needed to accept a condition (range 1-255).
- REQ-002: Parameter DWELL_CYCLES, default 16, WAIT cycles before TIMER asserts (range 1-65535).
- REQ-003: CLK  input  1  single clock; all state changes on the rising edge.
- REQ-004: RST  input  1  reset; asynchronous and active-high.
- REQ-005: Start  input  1  level; requests a route run, sampled only in IDLE.
- REQ-006: Abort  input  1  level; cancels a run in progress.
- REQ-007: Y  input  1  step-condition-met, returned by the downstream condition selector.
- REQ-008: Selector  output  5  current step index, 0-15, fed to the condition selector.
- REQ-009: Enable  output  1  high while a step condition is being evaluated (ARM and WAIT states).
- REQ-010: TIMER  output  1  dwell timer expired for the current step.
- REQ-011: Motor  output  2  train drive: 00 stop, 01 forward, 10 reverse; 11 never driven.
- REQ-012: Busy  output  1  high in every state except IDLE.
- REQ-013: Done  output  1  one-cycle pulse on route completion.

Function
- REQ-014: FSM states: IDLE, ARM, WAIT, ADVANCE, DONE; all outputs registered or decoded from registered state only.
- REQ-015: IDLE: Selector=0, Enable=0, Motor=00; Start=1 -> ARM at next edge.
- REQ-016: ARM: lasts exactly one cycle; clears debounce and dwell counters; Enable=1; -> WAIT.
- REQ-017: WAIT: Enable=1; debounce counter +1 per cycle with Y=1, cleared to 0 on any cycle with Y=0.
- REQ-018: WAIT: when the debounce counter reaches DEBOUNCE_CYCLES -> ADVANCE; Y=1 for DEBOUNCE_CYCLES consecutive WAIT cycles gives exactly DEBOUNCE_CYCLES WAIT cycles.
- REQ-019: Dwell counter: +1 per WAIT cycle for every step; saturates at DWELL_CYCLES.
- REQ-020: TIMER=1 while in WAIT with dwell counter == DWELL_CYCLES; TIMER=0 in all other states.
- REQ-021: ADVANCE: Enable=0; Selector<15 -> Selector+1 and -> ARM; Selector==15 -> DONE, Selector held at 15.
- REQ-022: DONE: Done=1 for exactly one cycle; Motor=00; -> IDLE, Selector=0.
- REQ-023: Motor in ARM/WAIT/ADVANCE: Selector 0-5 -> 01; 6-9 -> 00; 10-15 -> 10.
- REQ-024: Abort=1 in any non-IDLE state -> IDLE at next edge with Selector=0 and counters cleared; no Done pulse.
- REQ-025: Abort priority: Abort over ADVANCE/DONE transitions; Abort in IDLE ignored and blocks Start in the same cycle.
- REQ-026: Start held high through DONE -> IDLE re-arms on the following cycle; no extra gating.
- REQ-027: Selector never exceeds 15; values 16-31 are never driven.
- REQ-028: Per-step latency with Y constantly high and default parameters: 1 ARM + 4 WAIT + 1 ADVANCE = 6 cycles.

Reset
- REQ-029: RST=1 -> immediately, without a clock edge: state IDLE, Selector=0, Enable=0, TIMER=0, Motor=00, Busy=0, Done=0, counters 0.
- REQ-030: RST asserted mid-run discards all progress; after RST release with Start=1, the run restarts at step 0.

Verification
- REQ-031: Y tied 1, Start pulsed 1 cycle -> Selector steps 0..15, each held 6 cycles; Done pulses 97 cycles after the start edge; Busy then falls.
- REQ-032: Step 0, Y pattern 1,1,1,0,1,1,1,1 in WAIT -> ADVANCE only after the final four 1s; Selector=0 for 1+8 cycles, then ADVANCE.
- REQ-033: Selector=2, Y driven from TIMER -> TIMER rises after 16 WAIT cycles; ADVANCE 4 cycles later; step lasts 1+20+1 cycles.
- REQ-034: Abort=1 at Selector=9 in WAIT -> next edge IDLE, Selector=0, Motor=00, Busy=0; Done stays 0.
- REQ-035: RST pulse asynchronous to CLK at Selector=12 -> outputs reach reset values before the next edge; Motor=00 immediately.
- REQ-036: Motor check during the full run -> 01 for steps 0-5, 00 for 6-9, 10 for 10-15, 00 in DONE.
